ibex_aes32_iter: RTL and testbench

- Sequential, parametrised successor to the combinational AES datapath in the Ibex EX stage.
- Executes the Zkne/Zknd 32-bit AES ops (aes32esi, aes32esmi, aes32dsi, aes32dsmi).
- Adds a SubWord mode (rs1 ^ SubWord/InvSubWord(rs2)) for key-schedule support.
- Uses a configurable number of shared S-boxes and an optional output register; EX stalls on valid_o the same way it does for multdiv.

---
 rtl/ibex_aes32_iter.sv | 173 +++++++++++++++++
 tb/tb_ibex_aes32_iter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_aes32_iter.sv
// Iterative AES datapath for the Zkne/Zknd aes32* instructions plus a SubWord mode.
// A small FSM time-multiplexes SboxCount shared S-boxes and holds the result until the consumer takes it.
module ibex_aes32_iter #(
   parameter int SboxCount = 1,
   parameter bit OutReg    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic        decrypt_i,
   input  logic        mix_i,
   input  logic        word_i,
   input  logic [1:0]  bs_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        ready_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   generate
      if (!(SboxCount == 1 || SboxCount == 2 || SboxCount == 4)) begin : g_bad_sbox_count
         $error("ibex_aes32_iter: SboxCount must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

   // With four S-boxes the word finishes in one pass, so the wrapped step of 0 is never used.
   localparam logic [1:0] CntStep = 2'(SboxCount % 4);
   localparam logic [1:0] CntLast = 2'(4 - SboxCount);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   // Forward and inverse S-box share one inverter; only the affine stages differ.
   function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
      logic [7:0] x;
      logic [7:0] y;
      x = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
      y = gf_inv(x);
      return inv ? y : (y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                        ^ {y[3:0], y[7:4]} ^ 8'h63);
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  cnt_q;
   logic [31:0] op_a_q, op_b_q, acc_q, res_q;
   logic [1:0]  bs_q;
   logic        mix_q, dec_q, word_q;

   logic [1:0]  lane     [SboxCount];
   logic [7:0]  sbox_in  [SboxCount];
   logic [7:0]  sbox_out [SboxCount];
   logic [31:0] word_sub, t_mix, t_rot, sub_res;
   logic [7:0]  s, s2, s3;
   logic        last_sub;

   assign last_sub = (state_q == SUB) && (!word_q || cnt_q == CntLast);

   // S-box 0 doubles as the byte-mode S-box; word mode walks lanes upward from the counter.
   always_comb begin
      word_sub = acc_q;
      for (int j = 0; j < SboxCount; j++) begin
         lane[j]    = cnt_q + 2'(j);
         sbox_in[j] = op_b_q[8*lane[j] +: 8];
      end
      if (!word_q) sbox_in[0] = op_b_q[8*bs_q +: 8];
      for (int j = 0; j < SboxCount; j++) begin
         sbox_out[j]                = sbox(sbox_in[j], dec_q);
         word_sub[8*lane[j] +: 8]   = sbox_out[j];
      end
   end

   // Byte mode: optional partial (Inv)MixColumn column, then rotate into the selected byte position.
   always_comb begin
      s  = sbox_out[0];
      s2 = xtime(s);
      s3 = s2 ^ s;
      if (!mix_q)     t_mix = {24'h0, s};
      else if (dec_q) t_mix = {gf_mul(s, 8'h0B), gf_mul(s, 8'h0D), gf_mul(s, 8'h09), gf_mul(s, 8'h0E)};
      else            t_mix = {s3, s, s, s2};
      unique case (bs_q)
         2'd0:    t_rot = t_mix;
         2'd1:    t_rot = {t_mix[23:0], t_mix[31:24]};
         2'd2:    t_rot = {t_mix[15:0], t_mix[31:16]};
         default: t_rot = {t_mix[7:0],  t_mix[31:8]};
      endcase
      sub_res = op_a_q ^ (word_q ? word_sub : t_rot);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; kill overrides everything except reset.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = SUB;
         SUB:     if (last_sub) state_d = (!OutReg && ready_i) ? IDLE : DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill_i) state_d = IDLE;
   end

   // Operand capture, lane counter, partial-word accumulator and result register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 2'd0;
         op_a_q <= 32'h0;
         op_b_q <= 32'h0;
         acc_q  <= 32'h0;
         res_q  <= 32'h0;
         bs_q   <= 2'd0;
         mix_q  <= 1'b0;
         dec_q  <= 1'b0;
         word_q <= 1'b0;
      end else begin
         if (state_q == IDLE && start_i && !kill_i) begin
            op_a_q <= rs1_i;
            op_b_q <= rs2_i;
            bs_q   <= bs_i;
            mix_q  <= mix_i;
            dec_q  <= decrypt_i;
            word_q <= word_i;
            cnt_q  <= 2'd0;
            acc_q  <= 32'h0;
         end else if (state_q == SUB && !kill_i) begin
            cnt_q <= cnt_q + CntStep;
            acc_q <= word_sub;
            if (last_sub) res_q <= sub_res;
         end
         if (kill_i) cnt_q <= 2'd0;
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign valid_o  = (state_q == DONE) || (!OutReg && last_sub);
   assign result_o = (!OutReg && state_q == SUB) ? sub_res : res_q;

endmodule

// File: tb/tb_ibex_aes32_iter.sv
// Directed bench for ibex_aes32_iter across three S-box / output-register configurations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ibex_aes32_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, kill, dec, mix, word, ready;
   logic [1:0]  bs;
   logic [31:0] rs1, rs2;
   logic        start  [3];
   logic        busy   [3];
   logic        valid  [3];
   logic [31:0] result [3];

   int tests_run = 0;
   int fail_cnt  = 0;

   ibex_aes32_iter #(.SboxCount(1), .OutReg(1'b1)) u_s1_reg (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .kill_i(kill), .decrypt_i(dec),
      .mix_i(mix), .word_i(word), .bs_i(bs), .rs1_i(rs1), .rs2_i(rs2), .ready_i(ready),
      .busy_o(busy[0]), .valid_o(valid[0]), .result_o(result[0]));

   ibex_aes32_iter #(.SboxCount(4), .OutReg(1'b0)) u_s4_comb (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .kill_i(kill), .decrypt_i(dec),
      .mix_i(mix), .word_i(word), .bs_i(bs), .rs1_i(rs1), .rs2_i(rs2), .ready_i(ready),
      .busy_o(busy[1]), .valid_o(valid[1]), .result_o(result[1]));

   ibex_aes32_iter #(.SboxCount(2), .OutReg(1'b1)) u_s2_reg (
      .clk_i(clk), .rst_i(rst), .start_i(start[2]), .kill_i(kill), .decrypt_i(dec),
      .mix_i(mix), .word_i(word), .bs_i(bs), .rs1_i(rs1), .rs2_i(rs2), .ready_i(ready),
      .busy_o(busy[2]), .valid_o(valid[2]), .result_o(result[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One full transaction with ready held high; operands are scrambled right after acceptance.
   task automatic do_op(input int d, input int lat, input logic o_dec, input logic o_mix,
                        input logic o_word, input logic [1:0] o_bs, input logic [31:0] o_rs1,
                        input logic [31:0] o_rs2, input logic [31:0] exp, input string tag);
      @(negedge clk);
      dec = o_dec; mix = o_mix; word = o_word; bs = o_bs; rs1 = o_rs1; rs2 = o_rs2;
      start[d] = 1'b1;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         start[d] = 1'b0;
         dec = ~o_dec; mix = ~o_mix; word = ~o_word; bs = ~o_bs; rs1 = ~o_rs1; rs2 = ~o_rs2;
         check({tag, " busy"}, 32'(busy[d]), 32'd1);
         if (c < lat) check({tag, " early valid"}, 32'(valid[d]), 32'd0);
         else begin
            check({tag, " valid"}, 32'(valid[d]), 32'd1);
            check({tag, " result"}, result[d], exp);
         end
      end
      @(negedge clk);
      check({tag, " idle busy"}, 32'(busy[d]), 32'd0);
      check({tag, " idle valid"}, 32'(valid[d]), 32'd0);
   endtask

   initial begin
      foreach (start[i]) start[i] = 1'b0;
      rst = 1'b1; kill = 1'b0; dec = 1'b0; mix = 1'b0; word = 1'b0; ready = 1'b1;
      bs = 2'd0; rs1 = 32'h0; rs2 = 32'h0;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset busy", 32'(busy[d]), 32'd0);
         check("reset valid", 32'(valid[d]), 32'd0);
         check("reset result", result[d], 32'h0);
      end
      rst = 1'b0;

      // Byte mode on SboxCount=1, OutReg=1
      do_op(0, 2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0000_0053, 32'h0000_00ED, "esi bs0");
      do_op(0, 2, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0053_0000, 32'h00ED_0000, "esi bs2");
      do_op(0, 2, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'hA563_63C6, "esmi zero");
      do_op(0, 2, 1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h5A9C_9C39, "esmi ones");
      do_op(0, 2, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_0053, 32'h2CED_EDC1, "esmi xtime reduce");
      do_op(0, 2, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h5300_0000, 32'hC12C_EDED, "esmi bs3");
      do_op(0, 2, 1'b1, 1'b0, 1'b0, 2'd0, 32'h1234_5678, 32'h0000_0063, 32'h1234_5678, "dsi to zero");
      do_op(0, 2, 1'b1, 1'b0, 1'b0, 2'd3, 32'h0, 32'hED00_0000, 32'h5300_0000, "dsi bs3");
      do_op(0, 2, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_007C, 32'h0B0D_090E, "dsmi bs0");
      do_op(0, 2, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0000_7C00, 32'h0D09_0E0B, "dsmi bs1");

      // Word mode across configurations
      do_op(0, 5, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h6363_6363, "word s1");
      do_op(0, 5, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1111_1111, 32'hED63_007C, 32'h4211_4310, "word inv s1");
      do_op(1, 1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 32'h6363_6363, "word s4");
      do_op(2, 3, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0000_5300, 32'h6363_ED63, "word s2");
      do_op(1, 1, 1'b1, 1'b0, 1'b0, 2'd1, 32'hA5A5_A5A5, 32'h0000_ED00, 32'hA5A5_F6A5, "dsi s4");

      // Backpressure on the registered variant, with ignored start pulses
      @(negedge clk);
      dec = 1'b0; mix = 1'b0; word = 1'b0; bs = 2'd0; rs1 = 32'h0; rs2 = 32'h0000_0053;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; ready = 1'b0;
      check("bp early valid", 32'(valid[0]), 32'd0);
      @(negedge clk);
      check("bp valid 1", 32'(valid[0]), 32'd1);
      check("bp result 1", result[0], 32'h0000_00ED);
      start[0] = 1'b1; word = 1'b1; rs2 = 32'h0;
      @(negedge clk);
      check("bp valid 2", 32'(valid[0]), 32'd1);
      check("bp result 2", result[0], 32'h0000_00ED);
      @(negedge clk);
      check("bp valid 3", 32'(valid[0]), 32'd1);
      check("bp result 3", result[0], 32'h0000_00ED);
      start[0] = 1'b0; ready = 1'b1;
      @(negedge clk);
      check("bp released busy", 32'(busy[0]), 32'd0);
      word = 1'b0; mix = 1'b1; rs1 = 32'h0; rs2 = 32'h0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      check("b2b busy", 32'(busy[0]), 32'd1);
      check("b2b early valid", 32'(valid[0]), 32'd0);
      @(negedge clk);
      check("b2b valid", 32'(valid[0]), 32'd1);
      check("b2b result", result[0], 32'hA563_63C6);
      @(negedge clk);
      check("b2b idle", 32'(busy[0]), 32'd0);

      // Backpressure on the combinational-output variant latches the result
      @(negedge clk);
      dec = 1'b0; mix = 1'b0; word = 1'b0; bs = 2'd0; rs1 = 32'h0F0F_0F0F; rs2 = 32'h0000_0053;
      start[1] = 1'b1; ready = 1'b0;
      @(negedge clk);
      start[1] = 1'b0; rs2 = 32'h0; rs1 = 32'h0;
      check("s4 bp valid sub", 32'(valid[1]), 32'd1);
      check("s4 bp result sub", result[1], 32'h0F0F_0FE2);
      @(negedge clk);
      check("s4 bp valid done", 32'(valid[1]), 32'd1);
      check("s4 bp result done", result[1], 32'h0F0F_0FE2);
      ready = 1'b1;
      @(negedge clk);
      check("s4 bp idle", 32'(busy[1]), 32'd0);

      // Kill in the second SUB cycle of a word operation
      @(negedge clk);
      word = 1'b1; dec = 1'b0; rs1 = 32'h0; rs2 = 32'h0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      check("kill pre busy", 32'(busy[0]), 32'd1);
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", 32'(busy[0]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("kill valid stays low", 32'(valid[0]), 32'd0);
         @(negedge clk);
      end

      // Kill and start together in IDLE
      start[0] = 1'b1; kill = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; kill = 1'b0;
      check("kill+start busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      check("kill+start valid", 32'(valid[0]), 32'd0);

      // Reset while holding a result in DONE
      word = 1'b0; mix = 1'b0; bs = 2'd0; rs1 = 32'h0; rs2 = 32'h0000_0053;
      start[0] = 1'b1; ready = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      check("rst pre valid", 32'(valid[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ready = 1'b1;
      check("rst valid", 32'(valid[0]), 32'd0);
      check("rst result", result[0], 32'h0);
      check("rst busy", 32'(busy[0]), 32'd0);

      do_op(0, 2, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 32'h0000_5300, 32'h0000_ED00, "post rst esi");

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
